// File: rtl/tx_link_pkg.sv
// ----------------------------------------------------------------------------
// tx_link_pkg
//   Shared definitions for the 8b10b link framer: K-code symbols, the frame
//   scheduler state encoding, the {K,byte} symbol payload and a width helper.
// ----------------------------------------------------------------------------
package tx_link_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned SYM_W  = BYTE_W + 1;

   // Control symbols as {K flag, byte}
   localparam logic [SYM_W-1:0] K_COMMA = 9'h1BC;  // K28.5, inter-frame fill
   localparam logic [SYM_W-1:0] K_SOF   = 9'h1FB;  // K27.7, start of frame
   localparam logic [SYM_W-1:0] K_EOF   = 9'h1FD;  // K29.7, end of frame
   localparam logic [SYM_W-1:0] K_FILL  = 9'h1F7;  // K23.7, mid-frame underrun fill

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CHID = 2'd1,
      ST_DATA = 2'd2,
      ST_EOF  = 2'd3
   } tx_state_e;

   typedef struct packed {
      logic              k;
      logic [BYTE_W-1:0] data;
   } sym_t;

   // Index width that never collapses to zero for a single-entry vector
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tx_frame_ctrl_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin picker: finds the first request at or after the
//   pointer, wrapping around. The grant vector is qualified by the advance
//   strobe; the index and any-request flag are always valid.
// Ports
//   i_req    N      request vector
//   i_ptr    IDX_W  search start position (must be < N)
//   i_adv    1      grant qualifier; o_grant is zero when low
//   o_grant  N      one-hot grant (zero when no request or i_adv low)
//   o_idx    IDX_W  index of the selected request
//   o_any    1      at least one request is present
// ----------------------------------------------------------------------------
module rr_arbiter
   import tx_link_pkg::*;
#(
   parameter  int unsigned N     = 2,
   localparam int unsigned IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   input  logic             i_adv,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   logic [N-1:0]     w_grant_raw;
   logic [IDX_W-1:0] w_sel;
   logic             w_found;
   int unsigned      w_k;

   assign o_any   = |i_req;
   assign o_grant = w_grant_raw & {N{i_adv}};

   // Walk the request vector starting at the pointer, modulo N
   always_comb begin
      w_grant_raw = '0;
      o_idx       = '0;
      w_found     = 1'b0;
      w_k         = 0;
      w_sel       = '0;
      for (int unsigned i = 0; i < N; i++) begin
         w_k = 32'(i_ptr) + i;
         if (w_k >= N) begin
            w_k = w_k - N;
         end
         w_sel = IDX_W'(w_k);
         if (!w_found && i_req[w_sel]) begin
            w_found            = 1'b1;
            w_grant_raw[w_sel] = 1'b1;
            o_idx              = w_sel;
         end
      end
   end

endmodule

// File: rtl/tx_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tx_frame_ctrl
//   Symbol scheduler in front of the 8b10b serializer. Holds the next symbol
//   in sym_o; each sym_req_i consumes it and the following symbol is loaded
//   on the next edge. Frames are SOF, CHID, payload, EOF; channels are picked
//   round-robin at frame boundaries and K28.5 commas fill the gaps.
// Ports
//   clk_i, rst_ni          clock, async active-low reset
//   enable_i               allow new frames to start
//   sym_req_i              serializer load strobe
//   sym_o        [8:0]     pending symbol {K, byte}
//   ch_valid_i   [N]       per-channel byte valid
//   ch_data_i    [N*8]     per-channel byte, channel c at [8c+7:8c]
//   ch_last_i    [N]       per-channel last byte of frame
//   ch_ready_o   [N]       per-channel accept (combinational)
//   busy_o                 frame in progress
//   cur_ch_o     [CH_W]    granted channel
//   frame_done_o           pulse: EOF loaded
//   underrun_o             pulse: FILL loaded mid-frame
//   trunc_o                pulse: frame force-closed at MAX_LEN
// ----------------------------------------------------------------------------
module tx_frame_ctrl
   import tx_link_pkg::*;
#(
   parameter  int unsigned NUM_CH   = 2,
   parameter  int unsigned MAX_LEN  = 16,
   parameter  int unsigned IDLE_MIN = 2,
   localparam int unsigned CH_W     = idx_width(NUM_CH)
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     enable_i,
   input  logic                     sym_req_i,
   output logic [SYM_W-1:0]         sym_o,
   input  logic [NUM_CH-1:0]        ch_valid_i,
   input  logic [NUM_CH*BYTE_W-1:0] ch_data_i,
   input  logic [NUM_CH-1:0]        ch_last_i,
   output logic [NUM_CH-1:0]        ch_ready_o,
   output logic                     busy_o,
   output logic [CH_W-1:0]          cur_ch_o,
   output logic                     frame_done_o,
   output logic                     underrun_o,
   output logic                     trunc_o
);

   localparam int unsigned CNT_W  = $clog2(MAX_LEN + 1);
   localparam int unsigned IDLE_W = $clog2(IDLE_MIN + 1);

   tx_state_e          r_state, w_state_nxt;
   sym_t               r_sym, w_sym_nxt;
   logic [IDLE_W-1:0]  r_idle_cnt, w_idle_nxt;
   logic [CH_W-1:0]    r_rr_ptr, w_rr_nxt;
   logic [CH_W-1:0]    r_cur_ch, w_cur_nxt;
   logic [CNT_W-1:0]   r_byte_cnt, w_cnt_nxt;
   logic [NUM_CH-1:0]  r_grant_oh;
   logic               r_busy;
   logic               r_frame_done, w_done_nxt;
   logic               r_underrun, w_und_nxt;
   logic               r_trunc, w_trunc_nxt;

   logic [NUM_CH-1:0]  w_grant_oh;
   logic [CH_W-1:0]    w_arb_idx;
   logic               w_any_req;
   logic               w_idle_ok;
   logic               w_win;
   logic [NUM_CH-1:0]  w_sel_oh;
   logic               w_sel_valid;
   logic               w_sel_last;
   logic [BYTE_W-1:0]  w_sel_data;
   logic               w_at_max;

   assign w_idle_ok = (r_idle_cnt >= IDLE_W'(IDLE_MIN));
   assign w_win     = sym_req_i && (r_state == ST_IDLE) && enable_i && w_idle_ok && w_any_req;

   rr_arbiter #(.N(NUM_CH)) u_arb (
      .i_req   (ch_valid_i),
      .i_ptr   (r_rr_ptr),
      .i_adv   (w_win),
      .o_grant (w_grant_oh),
      .o_idx   (w_arb_idx),
      .o_any   (w_any_req)
   );

   // Granted channel's byte-stream signals, selected by the held one-hot grant
   assign w_sel_oh    = r_grant_oh & ch_valid_i;
   assign w_sel_valid = |w_sel_oh;
   assign w_sel_last  = |(r_grant_oh & ch_last_i);

   always_comb begin
      w_sel_data = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (r_grant_oh[c]) begin
            w_sel_data = ch_data_i[c*BYTE_W +: BYTE_W];
         end
      end
   end

   // The byte being loaded now would be the MAX_LEN-th of the frame
   assign w_at_max = (r_byte_cnt == CNT_W'(MAX_LEN - 1));

   // Next-state and next-symbol decode; nothing moves without a request
   always_comb begin
      w_state_nxt = r_state;
      w_sym_nxt   = r_sym;
      w_idle_nxt  = r_idle_cnt;
      w_rr_nxt    = r_rr_ptr;
      w_cur_nxt   = r_cur_ch;
      w_cnt_nxt   = r_byte_cnt;
      w_done_nxt  = 1'b0;
      w_und_nxt   = 1'b0;
      w_trunc_nxt = 1'b0;
      ch_ready_o  = '0;
      if (sym_req_i) begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_win) begin
                  w_sym_nxt   = K_SOF;
                  w_cur_nxt   = w_arb_idx;
                  w_rr_nxt    = (w_arb_idx == CH_W'(NUM_CH - 1)) ? '0 : w_arb_idx + CH_W'(1);
                  w_state_nxt = ST_CHID;
               end else begin
                  w_sym_nxt = K_COMMA;
                  if (!w_idle_ok) begin
                     w_idle_nxt = r_idle_cnt + IDLE_W'(1);
                  end
               end
            end
            ST_CHID: begin
               w_sym_nxt   = '{k: 1'b0, data: BYTE_W'(r_cur_ch)};
               w_cnt_nxt   = '0;
               w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
               if (w_sel_valid) begin
                  ch_ready_o = w_sel_oh;
                  w_sym_nxt  = '{k: 1'b0, data: w_sel_data};
                  w_cnt_nxt  = r_byte_cnt + CNT_W'(1);
                  if (w_sel_last) begin
                     w_state_nxt = ST_EOF;
                  end else if (w_at_max) begin
                     w_state_nxt = ST_EOF;
                     w_trunc_nxt = 1'b1;
                  end
               end else begin
                  w_sym_nxt = K_FILL;
                  w_und_nxt = 1'b1;
               end
            end
            ST_EOF: begin
               w_sym_nxt   = K_EOF;
               w_done_nxt  = 1'b1;
               w_idle_nxt  = '0;
               w_state_nxt = ST_IDLE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers; pulses last one cycle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= ST_IDLE;
         r_sym        <= K_COMMA;
         r_idle_cnt   <= '0;
         r_rr_ptr     <= '0;
         r_cur_ch     <= '0;
         r_byte_cnt   <= '0;
         r_grant_oh   <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_underrun   <= 1'b0;
         r_trunc      <= 1'b0;
      end else begin
         r_frame_done <= w_done_nxt;
         r_underrun   <= w_und_nxt;
         r_trunc      <= w_trunc_nxt;
         if (sym_req_i) begin
            r_state    <= w_state_nxt;
            r_sym      <= w_sym_nxt;
            r_idle_cnt <= w_idle_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_cur_ch   <= w_cur_nxt;
            r_byte_cnt <= w_cnt_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            if (w_win) begin
               r_grant_oh <= w_grant_oh;
            end
         end
      end
   end

   assign sym_o        = r_sym;
   assign busy_o       = r_busy;
   assign cur_ch_o     = r_cur_ch;
   assign frame_done_o = r_frame_done;
   assign underrun_o   = r_underrun;
   assign trunc_o      = r_trunc;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tx_frame_ctrl
//   Scoreboard bench: the driver runs a frame-level reference model on every
//   symbol request and queues the expected symbol/flags; a negedge monitor
//   pops and compares whenever the DUT has loaded a new symbol.
// ----------------------------------------------------------------------------
module tb_tx_frame_ctrl;

   localparam int NCH  = 2;
   localparam int MLEN = 16;
   localparam int IMIN = 2;
   localparam int CHW  = (NCH <= 1) ? 1 : $clog2(NCH);

   localparam logic [8:0] S_COMMA = 9'h1BC;
   localparam logic [8:0] S_SOF   = 9'h1FB;
   localparam logic [8:0] S_EOF   = 9'h1FD;
   localparam logic [8:0] S_FILL  = 9'h1F7;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             enable = 1'b1;
   logic             sym_req = 1'b0;
   logic [8:0]       sym;
   logic [NCH-1:0]   ch_valid = '0;
   logic [NCH*8-1:0] ch_data = '0;
   logic [NCH-1:0]   ch_last = '0;
   logic [NCH-1:0]   ch_ready;
   logic             busy;
   logic [CHW-1:0]   cur_ch;
   logic             frame_done;
   logic             underrun;
   logic             trunc;

   always #5 clk = ~clk;

   tx_frame_ctrl #(.NUM_CH(NCH), .MAX_LEN(MLEN), .IDLE_MIN(IMIN)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .enable_i     (enable),
      .sym_req_i    (sym_req),
      .sym_o        (sym),
      .ch_valid_i   (ch_valid),
      .ch_data_i    (ch_data),
      .ch_last_i    (ch_last),
      .ch_ready_o   (ch_ready),
      .busy_o       (busy),
      .cur_ch_o     (cur_ch),
      .frame_done_o (frame_done),
      .underrun_o   (underrun),
      .trunc_o      (trunc)
   );

   typedef struct {
      logic [8:0] sym;
      bit         done;
      bit         und;
      bit         trn;
      bit         bsy;
      int         cur;
   } exp_t;

   exp_t           exp_q[$];
   logic [NCH-1:0] rdy_q[$];
   int             checks = 0;
   int             errors = 0;

   // Source byte streams, {last, byte}
   logic [8:0]     src_q[NCH][$];
   int             force_off[NCH];
   bit             m_enable = 1'b1;

   // Reference model state
   bit             m_in_frame = 1'b0;
   logic [8:0]     m_pend[$];
   int             m_cur = 0;
   int             m_cnt = 0;
   int             m_gap = 0;
   int             m_rr  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add_frame(input int c, input int len);
      for (int i = 0; i < len; i++) begin
         src_q[c].push_back({(i == len - 1) ? 1'b1 : 1'b0, 8'($urandom_range(255))});
      end
   endtask

   task automatic model_reset();
      m_in_frame = 1'b0;
      m_pend.delete();
      m_cur = 0;
      m_cnt = 0;
      m_gap = 0;
      m_rr  = 0;
      for (int c = 0; c < NCH; c++) force_off[c] = 0;
   endtask

   // One serializer request at the frame level
   task automatic model_step();
      exp_t           e;
      logic [NCH-1:0] rdy;
      bit             lastb;
      bit             found;
      rdy   = '0;
      found = 1'b0;
      e     = '{sym: S_COMMA, done: 1'b0, und: 1'b0, trn: 1'b0, bsy: 1'b0, cur: 0};
      if (m_pend.size() > 0) begin
         e.sym = m_pend.pop_front();
         if (e.sym == S_EOF) begin
            e.done = 1'b1;
            m_gap  = 0;
         end
      end else if (m_in_frame) begin
         if (ch_valid[m_cur]) begin
            rdy[m_cur] = 1'b1;
            e.sym      = {1'b0, src_q[m_cur][0][7:0]};
            lastb      = src_q[m_cur][0][8];
            void'(src_q[m_cur].pop_front());
            m_cnt++;
            if (lastb || m_cnt == MLEN) begin
               m_pend.push_back(S_EOF);
               m_in_frame = 1'b0;
               e.trn      = !lastb;
            end
         end else begin
            e.sym = S_FILL;
            e.und = 1'b1;
         end
      end else if (enable && m_gap >= IMIN && (|ch_valid)) begin
         for (int k = 0; k < NCH; k++) begin
            int ch;
            ch = (m_rr + k) % NCH;
            if (!found && ch_valid[ch]) begin
               found = 1'b1;
               m_cur = ch;
            end
         end
         m_rr       = (m_cur + 1) % NCH;
         e.sym      = S_SOF;
         m_pend.push_back({1'b0, 8'(m_cur)});
         m_in_frame = 1'b1;
         m_cnt      = 0;
      end else begin
         e.sym = S_COMMA;
         if (m_gap < IMIN) m_gap++;
      end
      e.bsy = m_in_frame || (m_pend.size() > 0);
      e.cur = m_cur;
      exp_q.push_back(e);
      rdy_q.push_back(rdy);
   endtask

   // Drive one cycle of stimulus just after the clock edge
   task automatic step(input bit req, input int stall_pct);
      logic [NCH*8-1:0] d;
      @(posedge clk);
      #1;
      d = '0;
      for (int c = 0; c < NCH; c++) begin
         bit v;
         v = (src_q[c].size() > 0) && ($urandom_range(99) >= stall_pct);
         if (req && force_off[c] > 0) begin
            v = 1'b0;
            force_off[c]--;
         end
         ch_valid[c] = v;
         if (v) begin
            d[c*8 +: 8] = src_q[c][0][7:0];
            ch_last[c]  = src_q[c][0][8];
         end else begin
            d[c*8 +: 8] = 8'($urandom_range(255));
            ch_last[c]  = 1'($urandom_range(1));
         end
      end
      ch_data = d;
      enable  = m_enable;
      sym_req = req;
      if (req) model_step();
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_sym"}, 32'(sym), 32'(S_COMMA));
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_cur"}, 32'(cur_ch), 0);
      chk({tag, "_ready"}, 32'(ch_ready), 0);
      chk({tag, "_pulses"}, {29'd0, frame_done, underrun, trunc}, 0);
   endtask

   task automatic do_reset();
      step(1'b0, 0);
      step(1'b0, 0);
      rst_n = 1'b0;
      #1;
      check_reset_state("midreset");
      chk("midreset_expq_drained", 32'(exp_q.size()), 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic run_until_cnt(input int ch, input int cnt);
      int n;
      n = 0;
      while (!(m_in_frame && m_cur == ch && m_cnt == cnt) && n < 80) begin
         step(1'b1, 0);
         n++;
      end
      chk("wait_budget", 32'(n < 80), 1);
   endtask

   // Monitor: compare after every load, check pulses stay low otherwise
   bit mon_loaded = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_loaded <= 1'b0;
      end else begin
         if (mon_loaded) begin
            if (exp_q.size() == 0) begin
               chk("exp_queue_empty", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("sym", 32'(sym), 32'(e.sym));
               chk("frame_done", 32'(frame_done), 32'(e.done));
               chk("underrun", 32'(underrun), 32'(e.und));
               chk("trunc", 32'(trunc), 32'(e.trn));
               chk("busy", 32'(busy), 32'(e.bsy));
               chk("cur_ch", 32'(cur_ch), 32'(e.cur));
            end
         end else begin
            chk("quiet_pulses", {29'd0, frame_done, underrun, trunc}, 0);
         end
         if (sym_req) begin
            if (rdy_q.size() == 0) begin
               chk("rdy_queue_empty", 1, 0);
            end else begin
               logic [NCH-1:0] r;
               r = rdy_q.pop_front();
               chk("ch_ready", 32'(ch_ready), 32'(r));
            end
         end else begin
            chk("ch_ready_noreq", 32'(ch_ready), 0);
         end
         mon_loaded <= sym_req;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Nothing valid: commas only
      repeat (5) step(1'b1, 0);

      // Single two-byte frame on ch0
      src_q[0].push_back(9'h0A1);
      src_q[0].push_back(9'h1A2);
      repeat (12) step(1'b1, 0);

      // Both channels busy with 1-byte frames: CHID alternates
      for (int i = 0; i < 4; i++) begin
         add_frame(0, 1);
         add_frame(1, 1);
      end
      repeat (40) step(1'b1, 0);

      // ch1 valid drops for two requests after its first byte
      add_frame(1, 4);
      run_until_cnt(1, 1);
      force_off[1] = 2;
      repeat (20) step(1'b1, 0);

      // 20-byte stream on ch0 exceeds MAX_LEN
      add_frame(0, 20);
      repeat (50) step(1'b1, 0);

      // Reset in the middle of a payload
      add_frame(0, 10);
      run_until_cnt(0, 3);
      do_reset();
      repeat (40) step(1'b1, 0);

      // Random traffic, gaps in requests, stalls and enable toggling
      for (int n = 0; n < 1500; n++) begin
         for (int c = 0; c < NCH; c++) begin
            if (src_q[c].size() < 4) add_frame(c, $urandom_range(1, 22));
         end
         m_enable = ($urandom_range(99) < 90);
         step($urandom_range(99) < 70, 25);
      end

      m_enable = 1'b1;
      repeat (3) step(1'b0, 0);
      chk("final_exp_q", 32'(exp_q.size()), 0);
      chk("final_rdy_q", 32'(rdy_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
